// File: rtl/dir_rom_arbiter.sv
// dir_rom_arbiter
// Round-robin arbiter that lets N_REQ requesters share one combinational
// direction ROM. Lookups run through two registered stages: stage 1 holds
// the ROM address and the owner id, and the output register captures the
// ROM data. When the output register is full and not taken, both stages
// stall and no new grant is issued.

module dir_rom_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*8-1:0]   req_addr,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           rom_a,
    input  logic [4:0]           rom_spo,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [4:0]           rsp_dir,
    output logic                 busy
);

    // Index reached by stepping 'offset' places up from 'base', wrapping
    // modulo N_REQ (works for any N_REQ, not only powers of two).
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base,
                                                input int unsigned   offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= 32'(N_REQ)) begin
            sum = sum - 32'(N_REQ);
        end else begin
            sum = sum;
        end
        return sum[IDW-1:0];
    endfunction

    // Priority pointer
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;

    // Stage 1: ROM address and owner of the lookup in flight
    logic             s1_valid_q;
    logic             s1_valid_d;
    logic [IDW-1:0]   s1_id_q;
    logic [IDW-1:0]   s1_id_d;
    logic [7:0]       rom_a_q;
    logic [7:0]       rom_a_d;

    // Output register
    logic             rsp_valid_q;
    logic             rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q;
    logic [IDW-1:0]   rsp_id_d;
    logic [4:0]       rsp_dir_q;
    logic [4:0]       rsp_dir_d;

    // Arbitration results
    logic             advance_s;
    logic             grant_found_s;
    logic [IDW-1:0]   grant_idx_s;
    logic [N_REQ-1:0] req_ready_s;
    logic             transfer_s;
    logic [7:0]       grant_addr_s;

    // The pipeline moves only when the output register is empty or being taken.
    always_comb begin
        advance_s = !rsp_valid_q || rsp_ready;
    end

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int unsigned k = 0; k < 32'(N_REQ); k++) begin
            if (!grant_found_s && req_valid[rr_index(ptr_q, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_index(ptr_q, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // One-hot accept strobe; suppressed on stall and while reset is held so
    // nothing upstream sees an accept that the flops cannot capture.
    always_comb begin
        req_ready_s = '0;
        if (grant_found_s && advance_s && rst_n) begin
            req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Transfer qualifier and the address selected for the granted requester.
    always_comb begin
        transfer_s   = |(req_valid & req_ready_s);
        grant_addr_s = req_addr[{grant_idx_s, 3'b000} +: 8];
    end

    // Pointer moves past the winner only when a transfer really happens.
    always_comb begin
        ptr_d = ptr_q;
        if (transfer_s) begin
            ptr_d = rr_index(grant_idx_s, 32'd1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stage 1 load: a transfer fills it, an idle advance empties it,
    // a stall holds everything including the ROM address.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        rom_a_d    = rom_a_q;
        if (advance_s) begin
            if (transfer_s) begin
                s1_valid_d = 1'b1;
                s1_id_d    = grant_idx_s;
                rom_a_d    = grant_addr_s;
            end else begin
                s1_valid_d = 1'b0;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Output register load: capture ROM data for a valid stage-1 entry.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_dir_d   = rsp_dir_q;
        if (advance_s) begin
            if (s1_valid_q) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = s1_id_q;
                rsp_dir_d   = rom_spo;
            end else begin
                rsp_valid_d = 1'b0;
            end
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers with asynchronous clear; reset drops any lookup in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            rom_a_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_dir_q   <= 5'h00;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            rom_a_q     <= rom_a_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_dir_q   <= rsp_dir_d;
        end
    end

    // Output drive from registered state.
    always_comb begin
        req_ready = req_ready_s;
        rom_a     = rom_a_q;
        rsp_valid = rsp_valid_q;
        rsp_id    = rsp_id_q;
        rsp_dir   = rsp_dir_q;
        busy      = s1_valid_q | rsp_valid_q;
    end

endmodule
